irq_pending_ctrl: RTL and testbench

//  Interrupt front-end that sits directly upstream of the 8-to-3 priority encoder.
//  - Captures rising edges on 8 raw request lines into a pending register.
//  - Applies a programmable mask and drives pend_out into the encoder's 8-bit input.
//  - Takes the encoder's index/valid back and presents one interrupt at a time to the
//    CPU over a req/ack/eoi handshake, clearing the serviced pending bit on ack.

---
 rtl/irq_pending_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_irq_pending_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
// Interrupt front-end placed directly upstream of an 8-to-3 priority encoder.
// Captures rising edges on eight raw request lines into a pending register,
// applies a programmable mask, and feeds pend_out into the external encoder.
// The encoder's index/valid come back and are presented to the CPU one at a
// time over a req/ack/eoi handshake; ack clears the serviced pending bit.
//
// Optional feature macro: IRQ_SYNC_EN
//   defined   : irq_in passes through a 2-flop synchronizer (may be async)
//   undefined : irq_in is registered once (must be synchronous to clk)
// -----------------------------------------------------------------------------
module irq_pending_ctrl #(
   parameter logic [7:0] MASK_RESET = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] irq_in,
   input  logic       mask_we,
   input  logic [7:0] mask_wdata,
   output logic [7:0] pend_out,
   input  logic [2:0] enc_id,
   input  logic       enc_valid,
   output logic       req,
   output logic [2:0] id_out,
   input  logic       ack,
   input  logic       eoi,
   output logic       busy,
   output logic [7:0] pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Input capture and edge detection
   logic [7:0] irq_q;
   logic [7:0] irq_prev_q;
   logic [7:0] rise;

`ifdef IRQ_SYNC_EN
   logic [7:0] irq_s1_q;

   // Two-flop synchronizer: irq_in may be asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s1_q <= 8'h00;
         irq_q    <= 8'h00;
      end else begin
         irq_s1_q <= irq_in;
         irq_q    <= irq_s1_q;
      end
   end
`else
   // Single input register: irq_in is already synchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 8'h00;
      end else begin
         irq_q <= irq_in;
      end
   end
`endif

   // Previous-sample register so only 0->1 transitions mark a line pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev_q <= 8'h00;
      end else begin
         irq_prev_q <= irq_q;
      end
   end

   assign rise = irq_q & ~irq_prev_q;

   // Pending, mask and handshake state
   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   state_t     state_q, state_d;
   logic       req_q, req_d;
   logic [2:0] id_q, id_d;
   logic       busy_q, busy_d;
   logic [7:0] ack_clr;
   logic [7:0] pend_vis;

   // Masked view handed to the encoder; mask never alters the raw pending bits
   assign pend_vis = pending_q & ~mask_q;

   // Next-state logic for the CPU handshake, with registered outputs
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      id_d    = id_q;
      busy_d  = busy_q;
      ack_clr = 8'h00;
      unique case (state_q)
         IDLE: begin
            if (enc_valid) begin
               state_d = REQ;
               id_d    = enc_id;
               req_d   = 1'b1;
            end
         end
         REQ: begin
            // The latched id is kept even if a higher-priority line arrives
            if (ack) begin
               state_d = SERVICE;
               req_d   = 1'b0;
               busy_d  = 1'b1;
               ack_clr = 8'h01 << id_q;
            end else if (!pend_vis[id_q]) begin
               // Line was masked while waiting: withdraw the request
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         SERVICE: begin
            if (eoi) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Pending update: a fresh edge on the bit being acked wins over the clear
   always_comb begin
      pending_d = (pending_q & ~ack_clr) | rise;
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   // Handshake state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         id_q    <= 3'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   // Pending and mask registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 8'h00;
         mask_q    <= MASK_RESET;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   assign pend_out = pend_vis;
   assign req      = req_q;
   assign id_out   = id_q;
   assign busy     = busy_q;
   assign pending  = pending_q;

`ifndef SYNTHESIS
   // id_out must not move while a request is outstanding
   a_id_stable : assert property (@(posedge clk) disable iff (!rst_n)
      req_q |=> (!req_q || $stable(id_q)));

   // A request and a service period never overlap
   a_req_busy_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(req_q && busy_q));
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Scoreboard bench: the driver applies stimulus, advances a behavioural model
// and queues the expected outputs; a monitor pops and compares on each cycle
// and on every new CPU request. Directed scenarios are followed by random
// traffic. The external priority encoder is modelled combinationally.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] pend_out;
   logic [2:0] enc_id;
   logic       enc_valid;
   logic       req;
   logic [2:0] id_out;
   logic       ack;
   logic       eoi;
   logic       busy;
   logic [7:0] pending;

   irq_pending_ctrl #(.MASK_RESET(8'hFF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .pend_out   (pend_out),
      .enc_id     (enc_id),
      .enc_valid  (enc_valid),
      .req        (req),
      .id_out     (id_out),
      .ack        (ack),
      .eoi        (eoi),
      .busy       (busy),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Highest set bit wins (bit 7 = highest priority)
   function automatic logic [2:0] prio_enc(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
      return r;
   endfunction

   assign enc_valid = |pend_out;
   assign enc_id    = prio_enc(pend_out);

`ifdef IRQ_SYNC_EN
   localparam int LAG = 2;
`else
   localparam int LAG = 1;
`endif

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] pend;
      logic [7:0] vis;
      logic       rq;
      logic       bsy;
      logic [2:0] id;
   } snap_t;

   snap_t      sq[$];
   logic [2:0] idq[$];
   logic [7:0] hist[$];   // irq_in values applied at past edges, newest last

   localparam int PH_IDLE = 0, PH_WAIT_ACK = 1, PH_IN_SERVICE = 2;
   int         m_phase;
   logic [7:0] m_pend, m_mask;
   logic [2:0] m_id;
   logic       m_req, m_busy;

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_pend  = 8'h00;
      m_mask  = 8'hFF;
      m_id    = 3'd0;
      m_req   = 1'b0;
      m_busy  = 1'b0;
      hist.delete();
      for (int i = 0; i < 4; i++) hist.push_back(8'h00);
      sq.delete();
      idq.delete();
   endtask

   // One clock edge of the specified behaviour, using the inputs applied for it
   task automatic model_edge();
      logic [7:0] visible, edges, cleared;
      visible = m_pend & ~m_mask;
      // A line counts as a new edge once its high level has crossed the input
      // stage (LAG edges ago) while the sample before that was low.
      edges   = hist[hist.size() - LAG] & ~hist[hist.size() - LAG - 1];
      cleared = 8'h00;
      case (m_phase)
         PH_IDLE: if (visible != 8'h00) begin
            m_phase = PH_WAIT_ACK;
            m_id    = prio_enc(visible);
            m_req   = 1'b1;
            idq.push_back(m_id);
         end
         PH_WAIT_ACK: if (ack) begin
            m_phase     = PH_IN_SERVICE;
            m_req       = 1'b0;
            m_busy      = 1'b1;
            cleared[m_id] = 1'b1;
         end else if (!visible[m_id]) begin
            m_phase = PH_IDLE;
            m_req   = 1'b0;
         end
         default: if (eoi) begin
            m_phase = PH_IDLE;
            m_busy  = 1'b0;
         end
      endcase
      m_pend = (m_pend & ~cleared) | edges;
      if (mask_we) m_mask = mask_wdata;
      hist.push_back(irq_in);
      void'(hist.pop_front());
      sq.push_back('{pend: m_pend, vis: m_pend & ~m_mask, rq: m_req, bsy: m_busy, id: m_id});
   endtask

   // ---------------- comparison helpers ----------------
   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      snap_t      s;
      logic       prev_req;
      logic [2:0] eid;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req = 1'b0;
         end else begin
            if (sq.size() > 0) begin
               s = sq.pop_front();
               cmp("mon_pending", pending, s.pend);
               cmp("mon_pend_out", pend_out, s.vis);
               cmp("mon_req", {7'd0, req}, {7'd0, s.rq});
               cmp("mon_busy", {7'd0, busy}, {7'd0, s.bsy});
               if (s.rq) cmp("mon_id_hold", {5'd0, id_out}, {5'd0, s.id});
            end
            if (req && !prev_req) begin
               if (idq.size() == 0) begin
                  cmp("mon_unexpected_req", {5'd0, id_out}, 8'hEE);
               end else begin
                  eid = idq.pop_front();
                  cmp("mon_req_id", {5'd0, id_out}, {5'd0, eid});
               end
            end
            prev_req = req;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                      input logic a, input logic e);
      #1;
      irq_in     = irq;
      mask_we    = we;
      mask_wdata = wd;
      ack        = a;
      eoi        = e;
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic expect_now(input string tag, input logic r, input logic [2:0] id,
                             input logic b, input logic [7:0] pnd, input logic [7:0] vis);
      @(negedge clk);
      cmp({tag, "_req"}, {7'd0, req}, {7'd0, r});
      if (r) cmp({tag, "_id"}, {5'd0, id_out}, {5'd0, id});
      cmp({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
      cmp({tag, "_pending"}, pending, pnd);
      cmp({tag, "_pend_out"}, pend_out, vis);
   endtask

   initial begin
      rst_n      = 1'b0;
      irq_in     = 8'h00;
      mask_we    = 1'b0;
      mask_wdata = 8'h00;
      ack        = 1'b0;
      eoi        = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("rst_req", {7'd0, req}, 8'h00);
      cmp("rst_busy", {7'd0, busy}, 8'h00);
      cmp("rst_id", {5'd0, id_out}, 8'h00);
      cmp("rst_pending", pending, 8'h00);
      cmp("rst_pend_out", pend_out, 8'h00);
      #1 rst_n = 1'b1;

      // Single line, full handshake
      cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      cyc(8'h20, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t1_req", 1'b1, 3'd5, 1'b0, 8'h20, 8'h20);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      expect_now("t1_ack", 1'b0, 3'd0, 1'b1, 8'h00, 8'h00);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      expect_now("t1_eoi", 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);

      // Simultaneous edges: priority order
      cyc(8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t2_first", 1'b1, 3'd6, 1'b0, 8'h44, 8'h44);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);
      expect_now("t2_second", 1'b1, 3'd2, 1'b0, 8'h04, 8'h04);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

      // Masked line stays pending, unmask exposes it
      cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
      cyc(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t3_masked", 1'b0, 3'd0, 1'b0, 8'h08, 8'h00);
      cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      idle(4);
      expect_now("t3_unmask", 1'b1, 3'd3, 1'b0, 8'h08, 8'h08);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

      // Masking during REQ withdraws the request but keeps the pending bit
      cyc(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t4_req", 1'b1, 3'd4, 1'b0, 8'h10, 8'h10);
      cyc(8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
      idle(3);
      expect_now("t4_withdrawn", 1'b0, 3'd0, 1'b0, 8'h10, 8'h00);
      cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      idle(4);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

      // New edge on the same bit as the ack clear: set wins
      cyc(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t5_req", 1'b1, 3'd1, 1'b0, 8'h02, 8'h02);
      cyc(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef IRQ_SYNC_EN
      cyc(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
`endif
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      expect_now("t5_ack", 1'b0, 3'd0, 1'b1, 8'h02, 8'h02);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);
      expect_now("t5_rereq", 1'b1, 3'd1, 1'b0, 8'h02, 8'h02);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset during SERVICE
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(8'h81, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t6_pre", 1'b0, 3'd0, 1'b1, 8'h81, 8'h81);
      #1 rst_n = 1'b0;
      #1;
      cmp("t6_async_req", {7'd0, req}, 8'h00);
      cmp("t6_async_busy", {7'd0, busy}, 8'h00);
      cmp("t6_async_pending", pending, 8'h00);
      cmp("t6_async_pend_out", pend_out, 8'h00);
      model_reset();
      irq_in = 8'h00;
      ack    = 1'b0;
      eoi    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      // Mask must have come back as all-ones: a fresh edge stays hidden
      cyc(8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(5);
      expect_now("t6_mask_rst", 1'b0, 3'd0, 1'b0, 8'h40, 8'h00);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] nirq;
         logic       we;
         logic [7:0] wd;
         nirq = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         we   = ($urandom_range(0, 15) == 0);
         wd   = 8'($urandom) & 8'($urandom);
         cyc(nirq, we, wd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      end
      idle(8);
      @(negedge clk);
      cmp("end_req_queue_empty", 8'(idq.size()), 8'h00);
      cmp("end_snap_queue_empty", 8'(sq.size()), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
